// File: rtl/data_memory_responder.sv
// Memory-stage data memory: one outstanding load or store, fixed-latency loads,
// single-cycle store acknowledge, and a pipeline stall while a request is in flight.
module data_memory_responder #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall,
    output logic [1:0]        dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_ACK  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic              rsp_fire;
    logic              in_range;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  hold_idx;
    logic              hold_err;
    logic [3:0]        lat_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // req_ready is high only in IDLE, so the requester holds its fields until then;
    // inputs are ignored while busy. rsp_valid is a one-cycle pulse with no backpressure.
    assign accept    = req_valid & req_ready;
    assign req_idx   = req_addr[IDX_W-1:0];
    assign in_range  = ((req_addr >> IDX_W) == '0);
    assign stall     = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = req_we ? WR_ACK : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == '0) begin
                    rsp_fire = 1'b1;
                    state_nx = IDLE;
                end
            end
            WR_ACK: begin
                rsp_fire = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt   <= '0;
            hold_idx  <= '0;
            hold_err  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= rsp_fire;
            rsp_err   <= 1'b0;
            if (accept) begin
                hold_idx <= req_idx;
                hold_err <= ~in_range;
                lat_cnt  <= req_we ? 4'd0 : LAT_M1;
            end else if (state == RD_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            // rsp_rdata only changes on a response; it holds between pulses.
            if (rsp_fire) begin
                rsp_err   <= hold_err;
                rsp_rdata <= (state == RD_WAIT && !hold_err) ? mem[hold_idx] : '0;
            end
        end
    end

    // Storage is not reset; a store commits on its accept edge.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_we && in_range) begin
            mem[req_idx] <= req_wdata;
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus randomized traffic
// checked against an array-based memory model and fixed latency rules.
module tb_data_memory_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, stall;
    logic [15:0] rsp_rdata;
    logic [1:0]  dbg_state;

    logic        sw_valid;
    logic        s1_ready, s1_valid, s1_err, s1_stall;
    logic [15:0] s1_rdata;
    logic [1:0]  s1_dbg;
    logic        s7_ready, s7_valid, s7_err, s7_stall;
    logic [15:0] s7_rdata;
    logic [1:0]  s7_dbg;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_mem [DEPTH];
    bit          written   [DEPTH];
    logic [16:0] exp_q [$];

    always #5 clk = ~clk;

    data_memory_responder #(.READ_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .stall(stall), .dbg_state(dbg_state)
    );

    data_memory_responder #(.READ_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(sw_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(s1_ready),
        .rsp_valid(s1_valid), .rsp_rdata(s1_rdata), .rsp_err(s1_err),
        .stall(s1_stall), .dbg_state(s1_dbg)
    );

    data_memory_responder #(.READ_LAT(7)) u_lat7 (
        .clk(clk), .rst(rst), .req_valid(sw_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(s7_ready),
        .rsp_valid(s7_valid), .rsp_rdata(s7_rdata), .rsp_err(s7_err),
        .stall(s7_stall), .dbg_state(s7_dbg)
    );

    function automatic logic [15:0] exp_rdata(input logic [15:0] a);
        return (a < DEPTH) ? model_mem[a[9:0]] : 16'h0000;
    endfunction

    function automatic void model_store(input logic [15:0] a, input logic [15:0] d);
        if (a < DEPTH) begin
            model_mem[a[9:0]] = d;
            written[a[9:0]]   = 1'b1;
        end
    endfunction

    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
    endtask

    // Called right after an accept edge; measures edges until rsp_valid.
    task automatic wait_rsp(input logic keep, input logic [15:0] next_a,
                            output int lat, output int stall_hi,
                            output logic [15:0] rd, output logic err, output logic idle_ok);
        lat = -1; stall_hi = 0; rd = '0; err = 1'b0; idle_ok = 1'b0;
        @(negedge clk);
        if (keep) req_addr = next_a;
        else req_valid = 1'b0;
        if (stall && !rsp_valid) stall_hi++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; err = rsp_err;
                idle_ok = req_ready && !stall;
                break;
            end
            if (stall) stall_hi++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0000", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || stall !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle: ready=%b stall=%b want 1/0", req_ready, stall);
        end
    endtask

    task automatic test_store_load;
        int lat, sh; logic [15:0] rd; logic err, ok;
        model_store(16'h0005, 16'h1234);
        issue(1'b1, 16'h0005, 16'h1234);
        wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        checks++; if (lat !== 1) begin failures++; $display("FAIL store_lat: got %0d want 1", lat); end
        checks++; if (rd !== 16'h0 || err !== 1'b0) begin failures++; $display("FAIL store_ack: rdata=%h err=%b want 0000/0", rd, err); end
        checks++; if (sh !== 1 || ok !== 1'b1) begin failures++; $display("FAIL store_stall: stall_cycles=%0d idle=%b want 1/1", sh, ok); end
        issue(1'b0, 16'h0005, 16'h0);
        wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL load_lat: got %0d want %0d", lat, LAT); end
        checks++; if (rd !== exp_rdata(16'h0005) || err !== 1'b0) begin
            failures++; $display("FAIL load_data: got %h err=%b want %h/0", rd, err, exp_rdata(16'h0005));
        end
        checks++; if (sh !== LAT) begin failures++; $display("FAIL load_stall: got %0d want %0d", sh, LAT); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h1234) begin
            failures++; $display("FAIL rdata_hold: valid=%b rdata=%h want 0/1234", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_handshake;
        int lat, sh; logic [15:0] rd; logic err, ok;
        logic [15:0] d1, d2;
        d1 = 16'($urandom); d2 = 16'($urandom);
        model_store(16'h0001, d1); issue(1'b1, 16'h0001, d1); wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        model_store(16'h0002, d2); issue(1'b1, 16'h0002, d2); wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        issue(1'b0, 16'h0001, 16'h0);
        wait_rsp(1'b1, 16'h0002, lat, sh, rd, err, ok);
        checks++; if (lat !== LAT || sh !== LAT) begin failures++; $display("FAIL hs_first_timing: lat=%0d stall=%0d want %0d/%0d", lat, sh, LAT, LAT); end
        checks++; if (rd !== exp_rdata(16'h0001)) begin failures++; $display("FAIL hs_first_data: got %h want %h", rd, exp_rdata(16'h0001)); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL hs_ready_after_rsp: got %b want 1", ok); end
        @(posedge clk);
        wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        checks++; if (lat !== LAT || sh !== LAT) begin failures++; $display("FAIL hs_second_timing: lat=%0d stall=%0d want %0d/%0d", lat, sh, LAT, LAT); end
        checks++; if (rd !== exp_rdata(16'h0002)) begin failures++; $display("FAIL hs_second_data: got %h want %h", rd, exp_rdata(16'h0002)); end
    endtask

    task automatic test_range;
        int lat, sh; logic [15:0] rd; logic err, ok;
        logic [15:0] d0;
        d0 = 16'($urandom);
        model_store(16'h0000, d0); issue(1'b1, 16'h0000, d0); wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        model_store(16'h0400, 16'hBEEF);
        issue(1'b1, 16'h0400, 16'hBEEF);
        wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        checks++; if (lat !== 1 || err !== 1'b1 || rd !== 16'h0) begin
            failures++; $display("FAIL oor_store: lat=%0d err=%b rdata=%h want 1/1/0000", lat, err, rd);
        end
        issue(1'b0, 16'h0000, 16'h0);
        wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        checks++; if (rd !== d0 || err !== 1'b0) begin failures++; $display("FAIL oor_no_alias: got %h err=%b want %h/0", rd, err, d0); end
        issue(1'b0, 16'hFFFF, 16'h0);
        wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        checks++; if (lat !== LAT || err !== 1'b1 || rd !== 16'h0) begin
            failures++; $display("FAIL oor_load: lat=%0d err=%b rdata=%h want %0d/1/0000", lat, err, rd, LAT);
        end
    endtask

    task automatic test_reset_mid_load;
        int lat, sh; logic [15:0] rd; logic err, ok;
        logic [15:0] d3;
        bit saw;
        d3 = 16'($urandom_range(1, 16'hFFFF));
        model_store(16'h0003, d3); issue(1'b1, 16'h0003, d3); wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        issue(1'b0, 16'h0003, 16'h0); wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        issue(1'b0, 16'h0003, 16'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ctrl: stall=%b ready=%b want 0/1", stall, req_ready); end
        checks++; if (rsp_rdata !== 16'h0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL async_reset_rsp: rdata=%h valid=%b err=%b want 0000/0/0", rsp_rdata, rsp_valid, rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL abort_no_rsp: saw rsp_valid=%b want 0", saw); end
        issue(1'b0, 16'h0003, 16'h0);
        wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
        checks++; if (lat !== LAT || rd !== d3) begin failures++; $display("FAIL mem_survives_reset: lat=%0d rdata=%h want %0d/%h", lat, rd, LAT, d3); end
    endtask

    task automatic test_random;
        int lat, sh; logic [15:0] rd; logic err, ok;
        logic we; logic [15:0] a, d; logic [16:0] exp;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(DEPTH, 16'hFFFF));
            else a = 16'($urandom_range(0, 15));
            if (!we && a < DEPTH && !written[a[9:0]]) we = 1'b1;
            d = 16'($urandom);
            exp_q.push_back(we ? {a >= DEPTH, 16'h0} : {a >= DEPTH, exp_rdata(a)});
            if (we) model_store(a, d);
            issue(we, a, d);
            wait_rsp(1'b0, 16'h0, lat, sh, rd, err, ok);
            exp = exp_q.pop_front();
            checks++; if (lat !== (we ? 1 : LAT)) begin failures++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, we ? 1 : LAT); end
            checks++; if ({err, rd} !== exp) begin failures++; $display("FAIL rand_rsp[%0d] we=%b addr=%h: got %b/%h want %b/%h", i, we, a, err, rd, exp[16], exp[15:0]); end
        end
    endtask

    task automatic test_latency_sweep;
        int l1, l7; logic [15:0] d, r1, r7;
        d = 16'($urandom_range(1, 16'hFFFF));
        l1 = -1; l7 = -1; r1 = '0; r7 = '0;
        @(negedge clk);
        sw_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0009; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        sw_valid = 1'b0;
        repeat (3) @(negedge clk);
        sw_valid = 1'b1; req_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sw_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (s1_valid && l1 < 0) begin l1 = k - 1; r1 = s1_rdata; end
            if (s7_valid && l7 < 0) begin l7 = k - 1; r7 = s7_rdata; end
            @(posedge clk);
        end
        checks++; if (l1 !== 1 || r1 !== d) begin failures++; $display("FAIL sweep_lat1: lat=%0d rdata=%h want 1/%h", l1, r1, d); end
        checks++; if (l7 !== 7 || r7 !== d) begin failures++; $display("FAIL sweep_lat7: lat=%0d rdata=%h want 7/%h", l7, r7, d); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sw_valid = 1'b0;
        test_reset;
        test_store_load;
        test_handshake;
        test_range;
        test_reset_mid_load;
        test_random;
        test_latency_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
